// File: rtl/btn_toggle_pkg.sv
// rtl/btn_toggle_pkg.sv - shared state encoding, default parameters and helpers for btn_toggle_gen
package btn_toggle_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 1000;
    localparam int DEF_REPEAT_PERIOD   = 250;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - reset-clearable two-flop synchroniser for one asynchronous input
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_toggle_gen.sv
// rtl/btn_toggle_gen.sv - pushbutton synchroniser, debounce FSM and single-cycle toggle pulse generator
// Optional auto-repeat while held: define BTN_AUTO_REPEAT_EN.
module btn_toggle_gen
    import btn_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_out,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulse_n, level_n;
    logic             rep_fire;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_q)
    );

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt;
    logic             rep_phase;
    logic             rep_hit;

    // A hit that would land next to the previous pulse is held, not skipped, so the counter never overruns.
    assign rep_hit  = rep_phase ? (rcnt == RP_LAST) : (rcnt == RD_LAST);
    assign rep_fire = (state == HELD) && sync_q && rep_hit && !t_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (state_n == HELD && state != HELD) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
        end else if (state == HELD && state_n == HELD) begin
            if (rep_fire) begin
                rcnt      <= '0;
                rep_phase <= 1'b1;
            end else if (!rep_hit) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        level_n = btn_level;
        case (state)
            IDLE: begin
                if (sync_q) begin
                    state_n = DB_PRESS;
                    cnt_n   = CNT_W'(1);
                end
            end
            DB_PRESS: begin
                if (!sync_q) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                    level_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_n = DB_RELEASE;
                    cnt_n   = CNT_W'(1);
                end else begin
                    pulse_n = rep_fire;
                end
            end
            DB_RELEASE: begin
                if (sync_q) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            t_out     <= 1'b0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            t_out     <= pulse_n;
            btn_level <= level_n;
            busy      <= (state_n == DB_PRESS) || (state_n == DB_RELEASE);
        end
    end

endmodule

// File: tb/tb_btn_toggle_gen.sv
// tb/tb_btn_toggle_gen.sv - directed and randomized checks of btn_toggle_gen against a run-length model
module tb_btn_toggle_gen;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic t_out, btn_level, busy;

    always #5 clk = ~clk;

    btn_toggle_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_out     (t_out),
        .btn_level (btn_level),
        .busy      (busy)
    );

    // Downstream toggle flip-flop fed by t_out
    logic q_tff;
    always @(posedge clk) begin
        if (rst) q_tff <= 1'b0;
        else     q_tff <= q_tff ^ t_out;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the level flips once D consecutive FSM-visible samples disagree with it.
    bit bh [8192];
    bit rh [8192];
    int edge_n  = -1;
    bit m_valid = 1'b0;
    bit m_level = 1'b0;
    bit m_pulse = 1'b0;
    bit m_q     = 1'b0;
    bit seen;
    int m_mcount = 0;
    int m_age    = 0;

    always @(posedge clk) begin
        edge_n++;
        bh[edge_n % 8192] = btn_in;
        rh[edge_n % 8192] = rst;
        if (rst) begin
            m_valid  = 1'b1;
            m_level  = 1'b0;
            m_mcount = 0;
            m_age    = 0;
            m_q      = 1'b0;
            m_pulse  = 1'b0;
        end else begin
            m_q     = m_q ^ m_pulse;
            m_pulse = 1'b0;
            seen = (edge_n >= 2 && !rh[(edge_n-1) % 8192] && !rh[(edge_n-2) % 8192])
                   ? bh[(edge_n-2) % 8192] : 1'b0;
            if (seen != m_level) begin
                m_mcount++;
                if (m_mcount == D) begin
                    m_level  = seen;
                    m_mcount = 0;
                    if (m_level) begin
                        m_pulse = 1'b1;
                        m_age   = 0;
                    end
                end
            end else begin
                if (m_level) begin
                    if (m_mcount != 0) begin
                        m_age = 0;
                    end else begin
                        m_age++;
                        if (REP && (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)))
                            m_pulse = 1'b1;
                    end
                end
                m_mcount = 0;
            end
        end
    end

    int   dut_pulses  = 0;
    int   first_pulse = -1;
    logic prev_t      = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("t_out", t_out, m_pulse);
            check("btn_level", btn_level, m_level);
            check("busy", busy, m_mcount != 0);
            check("tff_q", q_tff, m_q);
            if (t_out === 1'b1) begin
                check("no_adjacent_pulse", prev_t, 1'b0);
                dut_pulses++;
                if (first_pulse < 0) first_pulse = edge_n;
            end
            prev_t = t_out;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic mark();
        dut_pulses  = 0;
        first_pulse = -1;
    endtask

    int e, r;
    logic qb;

    initial begin
        rst = 1'b1;
        btn_in = 1'b0;
        step(3);
        check("reset_t_out", t_out, 0);
        check("reset_level", btn_level, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        step(2);

        // Clean press and release
        mark(); btn_in = 1'b1; e = edge_n + 1;
        step(20);
        check("s1_first_pulse_edge", first_pulse, e + 5);
        check("s1_pulse_count", dut_pulses, REP ? 4 : 1);
        check("s1_level_high", btn_level, 1);
        mark(); btn_in = 1'b0;
        step(10);
        check("s1_release_pulses", dut_pulses, 0);
        check("s1_level_low", btn_level, 0);

        // Bounce then stable press
        mark();
        btn_in = 1'b1; step(1);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; step(2);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; e = edge_n + 1;
        step(15);
        check("s2_first_pulse_edge", first_pulse, e + 5);
        check("s2_pulse_count", dut_pulses, REP ? 2 : 1);
        btn_in = 1'b0; step(10);

        // Release glitch absorbed, then genuine release
        btn_in = 1'b1; step(10);
        mark();
        btn_in = 1'b0; step(2);
        btn_in = 1'b1; step(10);
        check("s3_glitch_pulses", dut_pulses, 0);
        check("s3_glitch_level", btn_level, 1);
        mark();
        btn_in = 1'b0; step(8);
        check("s3_release_pulses", dut_pulses, 0);
        check("s3_release_level", btn_level, 0);

        // Reset in the middle of the press debounce
        btn_in = 1'b1; step(4);
        check("s4_busy_before_reset", busy, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("s4_reset_t_out", t_out, 0);
        check("s4_reset_level", btn_level, 0);
        check("s4_reset_busy", busy, 0);
        r = edge_n; mark();
        step(15);
        check("s4_first_pulse_edge", first_pulse, r + 6);
        check("s4_pulse_count", dut_pulses, REP ? 2 : 1);
        btn_in = 1'b0; step(10);

        // Long hold: auto-repeat when enabled
        mark(); btn_in = 1'b1; e = edge_n + 1;
        step(25);
        check("s5_first_pulse_edge", first_pulse, e + 5);
        check("s5_pulse_count", dut_pulses, REP ? 5 : 1);
        btn_in = 1'b0; step(10);

        // Back-to-back presses
        qb = q_tff; mark();
        btn_in = 1'b1; step(6);
        btn_in = 1'b0; step(6);
        btn_in = 1'b1; step(6);
        check("s6_pulse_count", dut_pulses, 2);
        btn_in = 1'b0; step(8);
        check("s6_tff_restored", q_tff, qb);

        // Randomized hold lengths with occasional reset
        repeat (150) begin
            btn_in = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 39) == 0);
            step($urandom_range(1, 30));
            rst = 1'b0;
        end
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
